// File: rtl/master_slave_hash_drbg_pkg.sv
// Shared widths, SHA-256 constants and FSM states for the two-level hash DRBG.
package master_slave_hash_drbg_pkg;

    localparam int unsigned DRBG_W = 256;
    localparam int unsigned CNT_W  = 64;

    localparam logic [DRBG_W-1:0] SHA_H0 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] SHA_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [2:0] {
        IDLE, M_INST, M_SEED, S_INST, WAIT_REQ, GEN, WAIT_SEED
    } state_t;

endpackage

// File: rtl/master_slave_hash_drbg_sha256_block.sv
// Iterative single-block SHA-256 of a 256-bit message: 1 load, 64 rounds, 1 finalize cycle.
module sha256_block
    import master_slave_hash_drbg_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DRBG_W-1:0] message,
    output logic              done,
    output logic [DRBG_W-1:0] digest
);

    logic [31:0] w [16];
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [6:0]  rnd;
    logic        busy;
    logic [31:0] t1, t2, w_next;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // One compression round plus the next schedule word from a 16-word sliding window.
    always_comb begin
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g))
           + SHA_K[rnd[5:0]] + w[0];
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        w_next = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
               + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            rnd    <= '0;
            digest <= '0;
            {a, b, c, d, e, f, g, h} <= '0;
            for (int i = 0; i < 16; i++) w[i] <= '0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy <= 1'b1;
                    rnd  <= '0;
                    {a, b, c, d, e, f, g, h} <= SHA_H0;
                    // Fixed padding: 0x80 marker, zeros, 64-bit length of 256 bits.
                    for (int i = 0; i < 8; i++) w[i] <= message[DRBG_W-1-32*i -: 32];
                    w[8] <= 32'h8000_0000;
                    for (int i = 9; i < 15; i++) w[i] <= '0;
                    w[15] <= 32'd256;
                end
            end else if (rnd == 7'd64) begin
                busy   <= 1'b0;
                done   <= 1'b1;
                digest <= {SHA_H0[255:224] + a, SHA_H0[223:192] + b, SHA_H0[191:160] + c,
                           SHA_H0[159:128] + d, SHA_H0[127:96]  + e, SHA_H0[95:64]   + f,
                           SHA_H0[63:32]   + g, SHA_H0[31:0]    + h};
            end else begin
                {a, b, c, d, e, f, g, h} <= {t1 + t2, a, b, c, d + t1, e, f, g};
                for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                w[15] <= w_next;
                rnd   <= rnd + 7'd1;
            end
        end
    end

endmodule

// File: rtl/master_slave_hash_drbg.sv
// Master/slave SHA-256 DRBG: master derives slave seeds, slave emits 256-bit words on request.
module master_slave_hash_drbg
    import master_slave_hash_drbg_pkg::*;
#(
    parameter int unsigned SEED_GENERATOR_MAX_CYCLE = 8,
    parameter int unsigned BITS_GENERATOR_MAX_CYCLE = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              is_master_mode,
    input  logic              next_seed,
    input  logic              next_bits,
    input  logic              catch_up_mode,
    input  logic [DRBG_W-1:0] entropy,
    output logic              init_ready,
    output logic              next_bits_ready,
    output logic [DRBG_W-1:0] random_bits,
    output logic [CNT_W-1:0]  reseed_counter
);

    state_t            state;
    logic              master, catching, pending;
    logic              nb_q, nb_prev, ns_q, ns_prev, cu_q;
    logic [DRBG_W-1:0] vm, vs;
    logic [31:0]       bits_cnt, seed_cnt;
    logic              hash_start, hash_done;
    logic [DRBG_W-1:0] hash_msg, hash_digest;
    logic              nb_edge, ns_edge;

    assign nb_edge = nb_q & ~nb_prev;
    assign ns_edge = ns_q & ~ns_prev;

    sha256_block u_sha (
        .clk     (clk),
        .reset   (reset),
        .start   (hash_start),
        .message (hash_msg),
        .done    (hash_done),
        .digest  (hash_digest)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            {master, catching, pending} <= '0;
            {nb_q, nb_prev, ns_q, ns_prev, cu_q} <= '0;
            vm <= '0;
            vs <= '0;
            bits_cnt <= '0;
            seed_cnt <= '0;
            hash_start <= 1'b0;
            hash_msg <= '0;
            init_ready <= 1'b0;
            next_bits_ready <= 1'b0;
            random_bits <= '0;
            reseed_counter <= '0;
        end else begin
            nb_q <= next_bits;
            nb_prev <= nb_q;
            ns_q <= next_seed;
            ns_prev <= ns_q;
            cu_q <= catch_up_mode;
            hash_start <= 1'b0;
            // Requests seen outside WAIT_REQ are held here; cleared when a GEN consumes them.
            if (nb_edge) pending <= 1'b1;
            case (state)
                IDLE: begin
                    master <= is_master_mode;
                    if (is_master_mode) begin
                        state <= M_INST;
                        hash_start <= 1'b1;
                        hash_msg <= entropy;
                    end else begin
                        state <= WAIT_SEED;
                    end
                end
                M_INST: if (hash_done) begin
                    vm <= hash_digest;
                    seed_cnt <= '0;
                    state <= M_SEED;
                    hash_start <= 1'b1;
                    hash_msg <= hash_digest + DRBG_W'(1);
                end
                M_SEED: if (hash_done) begin
                    vm <= vm + hash_digest + DRBG_W'(1);
                    state <= S_INST;
                    hash_start <= 1'b1;
                    hash_msg <= hash_digest;
                end
                S_INST: if (hash_done) begin
                    vs <= hash_digest;
                    bits_cnt <= '0;
                    reseed_counter <= reseed_counter + CNT_W'(1);
                    init_ready <= 1'b1;
                    if (master) seed_cnt <= seed_cnt + 32'd1;
                    state <= WAIT_REQ;
                end
                WAIT_REQ: begin
                    if (bits_cnt >= BITS_GENERATOR_MAX_CYCLE) begin
                        init_ready <= 1'b0;
                        if (!master) begin
                            state <= WAIT_SEED;
                        end else if (seed_cnt < SEED_GENERATOR_MAX_CYCLE) begin
                            state <= M_SEED;
                            hash_start <= 1'b1;
                            hash_msg <= vm + DRBG_W'(1);
                        end else begin
                            state <= M_INST;
                            hash_start <= 1'b1;
                            hash_msg <= entropy;
                        end
                    end else if (!master && ns_edge) begin
                        init_ready <= 1'b0;
                        state <= S_INST;
                        hash_start <= 1'b1;
                        hash_msg <= entropy;
                    end else if ((!master && cu_q) || nb_edge || pending) begin
                        catching <= !master && cu_q;
                        if (!(!master && cu_q)) pending <= 1'b0;
                        next_bits_ready <= 1'b0;
                        state <= GEN;
                        hash_start <= 1'b1;
                        hash_msg <= vs;
                    end
                end
                GEN: if (hash_done) begin
                    random_bits <= hash_digest;
                    vs <= vs + hash_digest + DRBG_W'(1);
                    bits_cnt <= bits_cnt + 32'd1;
                    if (!catching) next_bits_ready <= 1'b1;
                    state <= WAIT_REQ;
                end
                WAIT_SEED: if (ns_edge) begin
                    state <= S_INST;
                    hash_start <= 1'b1;
                    hash_msg <= entropy;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_master_slave_hash_drbg.sv
// Directed bench for master_slave_hash_drbg with an independent SHA-256 DRBG reference.
module tb_master_slave_hash_drbg;
    import master_slave_hash_drbg_pkg::*;

    localparam int LAT_GEN    = 69;
    localparam int LAT_SEED_M = 202;
    localparam int LAT_SEED_S = 69;
    localparam int LAT_RESEED = 135;
    localparam logic [255:0] HASH_OF_ZERO =
        256'h66687aadf862bd776c8fc18b8e9f8e20089714856ee233b3902a591d0d5f2925;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         is_master_mode = 1'b1;
    logic         next_seed = 1'b0;
    logic         next_bits = 1'b0;
    logic         catch_up_mode = 1'b0;
    logic [255:0] entropy = '0;
    logic         init_ready, next_bits_ready;
    logic [255:0] random_bits;
    logic [63:0]  reseed_counter;

    int n_checks = 0;
    int n_fail = 0;

    logic [255:0] m_vm, m_vs, m_seed, s1, w, ew;
    logic [255:0] mw [4];
    int           n, n2, exp_lat, rises;
    logic         prev_rdy, vm_seen;

    master_slave_hash_drbg #(
        .SEED_GENERATOR_MAX_CYCLE (2),
        .BITS_GENERATOR_MAX_CYCLE (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .is_master_mode  (is_master_mode),
        .next_seed       (next_seed),
        .next_bits       (next_bits),
        .catch_up_mode   (catch_up_mode),
        .entropy         (entropy),
        .init_ready      (init_ready),
        .next_bits_ready (next_bits_ready),
        .random_bits     (random_bits),
        .reseed_counter  (reseed_counter)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int s);
        return (x >> s) | (x << (32 - s));
    endfunction

    function automatic logic [255:0] sha(input logic [255:0] msg);
        logic [31:0] wk [64];
        logic [31:0] hv [8];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        hv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        for (int i = 0; i < 8; i++) wk[i] = msg[255-32*i -: 32];
        wk[8] = 32'h8000_0000;
        for (int i = 9; i < 15; i++) wk[i] = 32'h0;
        wk[15] = 32'h0000_0100;
        for (int i = 16; i < 64; i++)
            wk[i] = (ror(wk[i-2], 17) ^ ror(wk[i-2], 19) ^ (wk[i-2] >> 10)) + wk[i-7]
                  + (ror(wk[i-15], 7) ^ ror(wk[i-15], 18) ^ (wk[i-15] >> 3)) + wk[i-16];
        a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3];
        e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
        for (int t = 0; t < 64; t++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + wk[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hv[0] + a, hv[1] + b, hv[2] + c, hv[3] + d,
                hv[4] + e, hv[5] + f, hv[6] + g, hv[7] + h};
    endfunction

    task automatic model_minst(input logic [255:0] ent);
        m_vm = sha(ent);
    endtask

    task automatic model_seed();
        m_seed = sha(m_vm + 256'd1);
        m_vm = m_vm + m_seed + 256'd1;
    endtask

    task automatic model_gen(output logic [255:0] word);
        word = sha(m_vs);
        m_vs = m_vs + word + 256'd1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!init_ready && cnt < 1000);
    endtask

    // Raise next_bits and wait for a fresh rise of next_bits_ready.
    task automatic get_word(output logic [255:0] word, output int cnt);
        logic seen_low;
        next_bits = 1'b1;
        seen_low = !next_bits_ready;
        cnt = 0;
        do begin
            step();
            cnt++;
            if (!next_bits_ready) seen_low = 1'b1;
        end while (!(seen_low && next_bits_ready) && cnt < 1000);
        word = random_bits;
        next_bits = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        check_eq("rst_init_ready", 256'(init_ready), 256'd0);
        check_eq("rst_next_bits_ready", 256'(next_bits_ready), 256'd0);
        check_eq("rst_random_bits", random_bits, 256'd0);
        check_eq("rst_reseed_counter", 256'(reseed_counter), 256'd0);

        // Master bring-up from entropy = 0.
        reset = 1'b0;
        n = 0;
        vm_seen = 1'b0;
        do begin
            step();
            n++;
            if (!vm_seen && dut.state == M_SEED) begin
                vm_seen = 1'b1;
                check_eq("m_inst_vm", dut.vm, HASH_OF_ZERO);
            end
        end while (!init_ready && n < 1000);
        check_eq("m_seed_latency", 256'(n), 256'(LAT_SEED_M));
        check_eq("m_reseed_cnt_1", 256'(reseed_counter), 256'd1);
        model_minst(256'd0);
        model_seed();
        s1 = m_seed;
        m_vs = sha(m_seed);

        for (int k = 1; k <= 12; k++) begin
            get_word(w, n);
            model_gen(ew);
            check_eq($sformatf("m_word_%0d", k), w, ew);
            check_eq($sformatf("m_gen_latency_%0d", k), 256'(n), 256'(LAT_GEN));
            if (k <= 4) mw[k-1] = ew;
            step();
            if (k % 4 != 0) begin
                check_eq($sformatf("m_init_held_%0d", k), 256'(init_ready), 256'd1);
            end else begin
                check_eq($sformatf("m_init_fall_%0d", k), 256'(init_ready), 256'd0);
                if (k == 12) next_bits = 1'b1;
                wait_init(n2);
                if (k == 8) begin
                    model_minst(256'd1);
                    exp_lat = LAT_SEED_M;
                end else begin
                    exp_lat = LAT_RESEED;
                end
                model_seed();
                m_vs = sha(m_seed);
                check_eq($sformatf("m_reseed_latency_%0d", k), 256'(n2 + 1), 256'(exp_lat));
                check_eq($sformatf("m_reseed_cnt_%0d", k), 256'(reseed_counter), 256'(k / 4 + 1));
                if (k == 4) entropy = 256'd1;
            end
        end

        // Request raised while reseeding is served once seeding completes.
        get_word(w, n);
        model_gen(ew);
        check_eq("m_latched_word_13", w, ew);
        step();

        // Slave mode fed the master's first derived seed replays master words 1..4.
        reset = 1'b1;
        is_master_mode = 1'b0;
        next_bits = 1'b0;
        step();
        reset = 1'b0;
        entropy = s1;
        repeat (3) step();
        check_eq("s_idle_init_ready", 256'(init_ready), 256'd0);
        next_seed = 1'b1;
        wait_init(n);
        next_seed = 1'b0;
        check_eq("s_seed_latency", 256'(n), 256'(LAT_SEED_S));
        check_eq("s_reseed_cnt_1", 256'(reseed_counter), 256'd1);
        for (int k = 1; k <= 4; k++) begin
            get_word(w, n);
            check_eq($sformatf("s_word_%0d", k), w, mw[k-1]);
            check_eq($sformatf("s_gen_latency_%0d", k), 256'(n), 256'(LAT_GEN));
            step();
        end
        check_eq("s_init_fall", 256'(init_ready), 256'd0);
        repeat (20) step();
        check_eq("s_waits_for_seed", 256'(init_ready), 256'd0);

        // Catch-up runs the whole period silently and leaves the last word visible.
        entropy = 256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;
        m_vs = sha(entropy);
        for (int k = 0; k < 4; k++) model_gen(ew);
        next_seed = 1'b1;
        wait_init(n);
        next_seed = 1'b0;
        check_eq("cu_seed_latency", 256'(n), 256'(LAT_SEED_S));
        check_eq("cu_reseed_cnt_2", 256'(reseed_counter), 256'd2);
        catch_up_mode = 1'b1;
        rises = 0;
        prev_rdy = next_bits_ready;
        n = 0;
        do begin
            step();
            n++;
            if (next_bits_ready && !prev_rdy) rises++;
            prev_rdy = next_bits_ready;
        end while (init_ready && n < 2000);
        catch_up_mode = 1'b0;
        check_eq("cu_init_fall", 256'(init_ready), 256'd0);
        check_eq("cu_ready_rises", 256'(rises), 256'd0);
        check_eq("cu_ready_low", 256'(next_bits_ready), 256'd0);
        check_eq("cu_last_word", random_bits, ew);

        // Reset during a GEN aborts it; restart reproduces the first word.
        reset = 1'b1;
        is_master_mode = 1'b1;
        entropy = 256'd0;
        step();
        reset = 1'b0;
        wait_init(n);
        check_eq("r_seed_latency_a", 256'(n), 256'(LAT_SEED_M));
        get_word(w, n);
        check_eq("r_word_1a", w, mw[0]);
        step();
        next_bits = 1'b1;
        repeat (30) step();
        reset = 1'b1;
        step();
        check_eq("r_init_ready", 256'(init_ready), 256'd0);
        check_eq("r_next_bits_ready", 256'(next_bits_ready), 256'd0);
        check_eq("r_random_bits", random_bits, 256'd0);
        check_eq("r_reseed_counter", 256'(reseed_counter), 256'd0);
        next_bits = 1'b0;
        reset = 1'b0;
        wait_init(n);
        check_eq("r_seed_latency_b", 256'(n), 256'(LAT_SEED_M));
        get_word(w, n);
        check_eq("r_word_1b", w, mw[0]);
        check_eq("r_gen_latency", 256'(n), 256'(LAT_GEN));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
